core_exec_ctrl: RTL
===================

CORE_EXEC_CTRL -- requirements
Module: core_exec_ctrl

Interface
REQ-001 Parameter DIV_W, default 32: width of the prescaler divide value.
REQ-002 Parameter HOLD_CYCLES, default 4: number of cycles the core is held in reset after block reset release.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low.
REQ-005 run_req  input  1  single-cycle pulse requesting free-running execution.
REQ-006 halt_req  input  1  single-cycle pulse requesting a stop.
REQ-007 step_req  input  1  single-cycle pulse requesting execution of exactly one instruction.
REQ-008 div_val  input  DIV_W  prescaler value; the core advances once per div_val+1 cycles.
REQ-009 bp_en  input  1  breakpoint enable.
REQ-010 bp_addr  input  32  breakpoint PC.
REQ-011 pc_in  input  32  current core PC.
REQ-012 core_rst  output  1  active-high synchronous reset to the core.
REQ-013 core_en  output  1  single-cycle clock-enable strobe to the core; each strobe equals one instruction.
REQ-014 state  output  2  FSM state encoding: INIT=0, HALT=1, RUN=2, STEP=3.
REQ-015 bp_hit  output  1  single-cycle pulse when a breakpoint stops RUN.
REQ-016 retired  output  32  count of core_en strobes issued.

Function
REQ-017 The FSM SHALL have states INIT, HALT, RUN and STEP, all registered.
REQ-018 In INIT, core_rst SHALL be 1 for exactly HOLD_CYCLES cycles after rst deasserts; the FSM SHALL then go to HALT with core_rst=0.
REQ-019 In INIT, all requests SHALL be ignored.
REQ-020 Request priority SHALL be halt_req > step_req > run_req when requests arrive in the same cycle.
REQ-021 HALT: run_req SHALL go to RUN and step_req SHALL go to STEP, both on the next edge; core_en SHALL be 0.
REQ-022 RUN: halt_req SHALL go to HALT on the next edge, with no core_en in that cycle or afterwards.
REQ-023 RUN: step_req SHALL be ignored.
REQ-024 STEP: the FSM SHALL issue exactly one core_en, then return to HALT on the same edge as that strobe.
REQ-025 STEP: halt_req SHALL abort the step with no strobe.
REQ-026 Prescaler: the count SHALL clear on entry to RUN or STEP and SHALL increment each cycle in RUN or STEP.
REQ-027 A tick SHALL occur when count >= div_val; the count SHALL then clear.
REQ-028 core_en SHALL equal tick gated by state RUN or STEP. With div_val=0, core_en SHALL assert in the first cycle of RUN.
REQ-029 Latency: a request accepted at edge t SHALL produce the first core_en in cycle t+1+div_val.
REQ-030 A change to div_val mid-run SHALL take effect at the next comparison; a count already >= the new value SHALL tick immediately.
REQ-031 Breakpoint: in RUN, when a tick occurs with bp_en=1 and pc_in==bp_addr, core_en SHALL be suppressed, bp_hit SHALL pulse for 1 cycle, and the FSM SHALL go to HALT.
REQ-032 Skip-once: the first tick after leaving HALT SHALL ignore the breakpoint compare, so resuming from a breakpoint PC advances.
REQ-033 STEP SHALL never be stopped by a breakpoint.
REQ-034 retired SHALL increment by 1 on each core_en and SHALL wrap from 0xFFFFFFFF to 0.
REQ-035 retired SHALL clear only on rst.

Reset
REQ-036 While rst=0: state=INIT, core_rst=1, core_en=0, bp_hit=0, retired=0, prescaler count=0, skip-once flag=0, INIT hold counter=0.
REQ-037 Reset asserted mid-RUN or mid-STEP SHALL force these values immediately, asynchronously, with no further core_en.
REQ-038 After rst is released, the full HOLD_CYCLES INIT sequence SHALL repeat.

Structure
REQ-039 The state enum and encodings SHALL live in shared package core_ctrl_pkg, together with default HOLD_CYCLES.
REQ-040 The prescaler SHALL be a sub-module tick_gen (inputs clk, rst, clr, en, div_val; output tick); the FSM, breakpoint logic and counters stay in core_exec_ctrl.

Verification
REQ-041 Release rst, HOLD_CYCLES=4 -> core_rst=1 for 4 cycles, state=HALT on the 5th cycle, retired=0.
REQ-042 HALT, div_val=2, run_req -> core_en every 3rd cycle, first strobe 3 cycles after acceptance; halt_req after 4 strobes -> retired=4 and no further strobes.
REQ-043 HALT, div_val=0, step_req -> exactly 1 core_en, state back to HALT, retired increments by 1.
REQ-044 Breakpoint hit, then resume: bp_en=1, bp_addr=0x10, run with pc_in reaching 0x10 -> bp_hit pulse, no strobe, HALT. Subsequent run_req with pc_in=0x10 -> strobe issued (skip-once).
REQ-045 Same-cycle run_req+halt_req in HALT -> stays HALT. Same-cycle step_req+run_req -> STEP.
REQ-046 rst asserted mid-RUN with retired=0xFFFFFFFF -> immediate INIT, retired=0. Separately, wrap check: 0xFFFFFFFF plus one strobe -> 0.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core execution controller.
//   exec_state_e     : FSM state encoding, also the value driven on the
//                      controller's 'state' debug output.
//   HOLD_CYCLES_DEF  : default number of cycles the core is held in reset
//                      after the controller leaves reset.
//   is_exec_state()  : true for the states in which the core may advance.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } exec_state_e;

  localparam int HOLD_CYCLES_DEF = 4;

  function automatic logic is_exec_state(exec_state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/core_exec_ctrl_tick_gen.sv
// tick_gen: execution prescaler.
//   clk     : system clock
//   rst     : asynchronous active-low reset
//   clr     : clear the count (asserted on the edge that enters RUN/STEP)
//   en      : count while high (controller is in RUN or STEP)
//   div_val : tick once every div_val+1 enabled cycles
//   tick    : combinational, high in the cycle the count reaches div_val
// The compare is >= rather than == so that lowering div_val below the
// current count ticks immediately instead of waiting for a wrap.
module tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;

  always_comb begin
    tick    = en && (count_q >= div_val);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/core_exec_ctrl.sv
// core_exec_ctrl: run/halt/single-step controller for a core.
//   clk, rst          : system clock, asynchronous active-low reset
//   run_req, halt_req,
//   step_req          : request pulses (priority halt > step > run)
//   div_val           : prescaler, one instruction per div_val+1 cycles
//   bp_en, bp_addr,
//   pc_in             : breakpoint enable/address and current core PC
//   core_rst          : synchronous reset to the core (high in INIT)
//   core_en           : one-cycle strobe, one instruction per strobe
//   state             : FSM state (exec_state_e encoding)
//   bp_hit            : one-cycle pulse when a breakpoint stops RUN
//   retired           : wrapping count of core_en strobes
//
// Request handshake: run_req/halt_req/step_req are single-cycle pulses with
// no ready/acknowledge. A pulse is sampled on the next rising edge; if the
// current state has no use for it (INIT, or step/run while RUN/STEP) it is
// dropped and never remembered.
module core_exec_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int DIV_W       = 32,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_req,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic [DIV_W-1:0] div_val,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc_in,
  output logic             core_rst,
  output logic             core_en,
  output logic [1:0]       state,
  output logic             bp_hit,
  output logic [31:0]      retired
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  exec_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              skip_q, skip_d;
  logic [31:0]       retired_q, retired_d;

  logic tick;
  logic presc_clr;
  logic presc_en;
  logic bp_match;

  assign presc_en = is_exec_state(state_q);
  // skip_q masks the compare for the first tick after leaving HALT, so a
  // resume from the breakpoint PC executes that instruction.
  assign bp_match = bp_en && (pc_in == bp_addr) && !skip_q;

  tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (presc_clr),
    .en      (presc_en),
    .div_val (div_val),
    .tick    (tick)
  );

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    skip_d    = skip_q;
    presc_clr = 1'b0;
    core_en   = 1'b0;
    bp_hit    = 1'b0;

    case (state_q)
      ST_INIT: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_HALT;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_HALT: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (step_req) begin
          state_d   = ST_STEP;
          presc_clr = 1'b1;
          skip_d    = 1'b1;
        end else if (run_req) begin
          state_d   = ST_RUN;
          presc_clr = 1'b1;
          skip_d    = 1'b1;
        end
      end

      ST_RUN: begin
        // A halt in the same cycle as a tick wins: no strobe, no bp_hit.
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (tick) begin
          skip_d = 1'b0;
          if (bp_match) begin
            bp_hit  = 1'b1;
            state_d = ST_HALT;
          end else begin
            core_en = 1'b1;
          end
        end
      end

      ST_STEP: begin
        // Breakpoints are deliberately not consulted here.
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (tick) begin
          core_en = 1'b1;
          skip_d  = 1'b0;
          state_d = ST_HALT;
        end
      end

      default: state_d = ST_INIT;
    endcase

    retired_d = retired_q + 32'(core_en);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      hold_q    <= '0;
      skip_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      skip_q    <= skip_d;
      retired_q <= retired_d;
    end
  end

  assign core_rst = (state_q == ST_INIT);
  assign state    = state_q;
  assign retired  = retired_q;

endmodule
